tube_event_writer: RTL and testbench
====================================

Name: tube_event_writer

Overview:
- Write side of the event FIFO that the RPi drains through RD_CLK/RD_EN/RD_EMPTY/RD_VALID and OTUBEX/OTUBEY.
- On each scintillator coincidence, opens a fixed hit window and OR-accumulates drift-tube hits from layers 3A/3B/4A/4B.
- Pushes the packed event into the FIFO write port as 16-bit words {X[7:0], Y[7:0]}, which map one-to-one onto OTUBEX/OTUBEY at the read end.
- Sits between the tube/scintillator input pins and the FIFO write port, in the CLK domain.

Parameters:
- WINDOW, 16, hit accumulation window length in CLK cycles; legal range 1..255.
- SYNC_STAGES, 2, synchronizer depth for SCIN_COIN and tube inputs; minimum 2.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- SCIN_COIN  input  1  scintillator coincidence; asynchronous level, rising edge = trigger.
- TUBE3A  input  8  tube hit lines, layer 3A; asynchronous.
- TUBE3B  input  8  tube hit lines, layer 3B.
- TUBE4A  input  8  tube hit lines, layer 4A.
- TUBE4B  input  8  tube hit lines, layer 4B.
- WR_DATA  output  16  FIFO write word; [15:8] becomes OTUBEX, [7:0] becomes OTUBEY.
- WR_EN  output  1  FIFO write strobe; one word per high cycle.
- WR_FULL  input  1  FIFO full; no write occurs while high.
- BUSY  output  1  high in any state other than IDLE.
- DROP_CNT  output  8  saturating count of triggers ignored while BUSY.

Behaviour:
- Reset state: all outputs 0, state IDLE, synchronizers cleared, hit accumulators 0, window counter 0. Asserting RST mid-event discards the partial event; no word from it is written after release.
- Input conditioning:
  - SCIN_COIN and all 32 tube lines pass through SYNC_STAGES flops.
  - trig = synced SCIN_COIN & ~previous synced SCIN_COIN, a one-cycle pulse. Cycle E is the cycle trig is high.
- State machine: IDLE -> WINDOW -> WR0 -> WR1 -> [WRTS] -> IDLE.
  - IDLE: on trig, clear accumulators, load the window counter, go to WINDOW. Synced hits at E are already OR-ed in.
  - WINDOW: covers cycles E..E+WINDOW-1; each cycle, acc |= synced tube bits. After the last cycle, go to WR0 at E+WINDOW. WINDOW=1 means only cycle E is sampled.
  - WR0: WR_DATA = {acc3A, acc3B}. WR_EN = ~WR_FULL, combinational from state and WR_FULL. Advance on a cycle where WR_EN=1; otherwise hold with WR_DATA stable.
  - WR1: WR_DATA = {acc4A, acc4B}, same handshake. Go to WRTS if the feature is enabled, else IDLE.
- Write rules:
  - An event is always written, even if all accumulators are 0 (records an empty coincidence).
  - Minimum event latency, trig to last write: WINDOW+1 cycles without the feature, WINDOW+2 with it.
  - With WR_FULL low, consecutive words are written on back-to-back cycles.
  - WR_FULL may toggle arbitrarily; words are never duplicated, skipped, or reordered.
  - WR_DATA holds its last value in IDLE; it is only meaningful when WR_EN=1.
- Dead time: a trig in any non-IDLE state is ignored and DROP_CNT increments, saturating at 255 (no wrap).
- Simultaneous events: a trig in the same cycle the FSM returns to IDLE is dropped. A trig in the first IDLE cycle is accepted.
- Tube activity outside a window is ignored.

Optional Feature:
- Macro: TUBE_EVT_TIMESTAMP_EN.
- When defined:
  - Adds a 16-bit EVT_CNT register, reset to 0.
  - After WR1 the FSM enters WRTS and writes WR_DATA = EVT_CNT using the same handshake.
  - EVT_CNT increments when the WRTS write is accepted, wrapping 0xFFFF -> 0x0000.
  - Events are 3 words long.
- When undefined: no WRTS state, no counter, events are 2 words long.

Decomposition:
- Shared package qn17_pkg holds:
  - TUBE_W=8 and FIFO_W=16.
  - State encoding constants IDLE/WINDOW/WR0/WR1/WRTS.
  - EVT_WORDS, which is 2 or 3 depending on TUBE_EVT_TIMESTAMP_EN.
- One sub-module, sync_edge: parameterized-width SYNC_STAGES synchronizer with an optional rising-edge pulse output. It is instantiated for SCIN_COIN (edge used) and for the 32 tube bits (level only).

Test Plan:
- Reset check: RST pulse mid-WINDOW, with TUBE3A=0x01 held -> all outputs 0; no WR_EN for 50 cycles after release without a new trigger.
- Basic event: WINDOW=16, WR_FULL=0. SCIN_COIN rises; TUBE3A=0x81 for 1 cycle at E+3; TUBE4B=0x10 at E+15; TUBE3B=0x02 at E+16 -> writes 0x8100 then 0x0010 at E+16 and E+17. TUBE3B is excluded.
- Backpressure: same event with WR_FULL high for 5 cycles from E+16 -> WR_EN low for 5 cycles, WR_DATA held at 0x8100. Then exactly 0x8100 and 0x0010 are written once each.
- Dead time: 300 triggers spaced 4 cycles apart while the FIFO is held full -> DROP_CNT saturates at 0xFF; after WR_FULL drops, exactly one event is written.
- Empty event: trigger with no tube activity -> words 0x0000, 0x0000 are written.
- With TUBE_EVT_TIMESTAMP_EN: 3 events -> third words are 0x0000, 0x0001, 0x0002. Preload via 65536 events (or force) -> the word after 0xFFFF is 0x0000.

Source files
------------

// File: rtl/tube_event_writer_pkg.sv
// qn17_pkg: shared widths, FSM state codes and event geometry for the
// tube event writer.
// Optional feature macro: TUBE_EVT_TIMESTAMP_EN (adds a trailing counter word
// to every event, so EVT_WORDS becomes 3).
package qn17_pkg;

  localparam int TUBE_W = 8;
  localparam int FIFO_W = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WINDOW = 3'd1;
  localparam logic [2:0] ST_WR0    = 3'd2;
  localparam logic [2:0] ST_WR1    = 3'd3;
  localparam logic [2:0] ST_WRTS   = 3'd4;

`ifdef TUBE_EVT_TIMESTAMP_EN
  localparam int EVT_WORDS = 3;
`else
  localparam int EVT_WORDS = 2;
`endif

  // Accumulated hits of one event, ordered as the words leave the block.
  typedef struct packed {
    logic [TUBE_W-1:0] t3a;
    logic [TUBE_W-1:0] t3b;
    logic [TUBE_W-1:0] t4a;
    logic [TUBE_W-1:0] t4b;
  } tube_hits_t;

endpackage

// File: rtl/tube_event_writer_if.sv
// FIFO write port of the tube event writer.
//   WR_DATA  16  event word {X, Y}
//   WR_EN     1  one word accepted per high cycle
//   WR_FULL   1  FIFO full, blocks writes
// master: writer side; slave: FIFO side.
interface tube_event_writer_if;
  import qn17_pkg::*;

  logic [FIFO_W-1:0] WR_DATA;
  logic              WR_EN;
  logic              WR_FULL;

  modport master (output WR_DATA, output WR_EN, input WR_FULL);
  modport slave  (input WR_DATA, input WR_EN, output WR_FULL);

endinterface

// File: rtl/tube_event_writer_sync_edge.sv
// sync_edge: WIDTH-bit, STAGES-deep synchronizer with an optional
// rising-edge pulse output.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   d         asynchronous input
//   q         synchronized level
//   rise      one-cycle pulse per 0->1 of q (zero when EDGE_EN == 0)
module sync_edge #(
  parameter int WIDTH   = 1,
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

  if (EDGE_EN) begin : g_edge
    logic [WIDTH-1:0] q_prev;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q_prev <= '0;
      else     q_prev <= q;
    end
    assign rise = q & ~q_prev;
  end else begin : g_no_edge
    assign rise = '0;
  end

endmodule

// File: rtl/tube_event_writer.sv
// tube_event_writer: on each scintillator coincidence, OR-accumulates the
// four tube layers over a WINDOW-cycle hit window and pushes the event into
// the FIFO write port as {3A,3B} then {4A,4B}.
// Optional feature macro: TUBE_EVT_TIMESTAMP_EN appends a 16-bit event
// counter word (WRTS state).
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   SCIN_COIN         async coincidence level, rising edge triggers
//   TUBE3A..TUBE4B    async tube hit lines, 8 per layer
//   wr                FIFO write port (tube_event_writer_if.master)
//   BUSY              high outside IDLE
//   DROP_CNT          saturating count of triggers ignored while busy
//
// state     | meaning
// ST_IDLE   | waiting for trig; cycle E itself is sampled here
// ST_WINDOW | accumulating hits for cycles E+1..E+WINDOW-1
// ST_WR0    | offering {acc3A, acc3B}
// ST_WR1    | offering {acc4A, acc4B}
// ST_WRTS   | offering EVT_CNT (timestamp build only)
module tube_event_writer
  import qn17_pkg::*;
#(
  parameter int WINDOW      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SCIN_COIN,
  input  logic [TUBE_W-1:0] TUBE3A,
  input  logic [TUBE_W-1:0] TUBE3B,
  input  logic [TUBE_W-1:0] TUBE4A,
  input  logic [TUBE_W-1:0] TUBE4B,
  tube_event_writer_if.master wr,
  output logic              BUSY,
  output logic [7:0]        DROP_CNT
);

  localparam logic [7:0] WIN_LOAD = 8'(WINDOW - 1);

  logic              trig;
  logic              unused_scin_lvl;
  logic [4*TUBE_W-1:0] tube_s;
  logic [4*TUBE_W-1:0] unused_tube_rise;

  logic [2:0]        state;
  logic [7:0]        win_cnt;
  tube_hits_t        acc;
  logic [FIFO_W-1:0] hold;
`ifdef TUBE_EVT_TIMESTAMP_EN
  logic [FIFO_W-1:0] evt_cnt;
`endif

  sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_scin (
    .clk  (CLK),
    .rst  (RST),
    .d    (SCIN_COIN),
    .q    (unused_scin_lvl),
    .rise (trig)
  );

  sync_edge #(.WIDTH(4*TUBE_W), .STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_tube (
    .clk  (CLK),
    .rst  (RST),
    .d    ({TUBE3A, TUBE3B, TUBE4A, TUBE4B}),
    .q    (tube_s),
    .rise (unused_tube_rise)
  );

  // Write handshake is combinational so a word can leave on the same cycle
  // WR_FULL drops. Outside the write states WR_DATA shows the last word sent.
  always_comb begin
    wr.WR_EN   = 1'b0;
    wr.WR_DATA = hold;
    unique case (state)
      ST_WR0: begin
        wr.WR_EN   = ~wr.WR_FULL;
        wr.WR_DATA = {acc.t3a, acc.t3b};
      end
      ST_WR1: begin
        wr.WR_EN   = ~wr.WR_FULL;
        wr.WR_DATA = {acc.t4a, acc.t4b};
      end
`ifdef TUBE_EVT_TIMESTAMP_EN
      ST_WRTS: begin
        wr.WR_EN   = ~wr.WR_FULL;
        wr.WR_DATA = evt_cnt;
      end
`endif
      default: ;
    endcase
  end

  assign BUSY = (state != ST_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_IDLE;
      win_cnt  <= '0;
      acc      <= '0;
      hold     <= '0;
      DROP_CNT <= '0;
`ifdef TUBE_EVT_TIMESTAMP_EN
      evt_cnt  <= '0;
`endif
    end else begin
      if (wr.WR_EN) hold <= wr.WR_DATA;
      if (trig && state != ST_IDLE && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;

      unique case (state)
        ST_IDLE: begin
          if (trig) begin
            acc     <= tube_s;
            win_cnt <= WIN_LOAD;
            state   <= (WINDOW == 1) ? ST_WR0 : ST_WINDOW;
          end
        end
        ST_WINDOW: begin
          acc     <= acc | tube_s;
          win_cnt <= win_cnt - 8'd1;
          if (win_cnt == 8'd1) state <= ST_WR0;
        end
        ST_WR0: if (wr.WR_EN) state <= ST_WR1;
        ST_WR1: begin
`ifdef TUBE_EVT_TIMESTAMP_EN
          if (wr.WR_EN) state <= ST_WRTS;
`else
          if (wr.WR_EN) state <= ST_IDLE;
`endif
        end
`ifdef TUBE_EVT_TIMESTAMP_EN
        ST_WRTS: begin
          if (wr.WR_EN) begin
            evt_cnt <= evt_cnt + 16'd1;
            state   <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tube_event_writer.sv
// Bench for tube_event_writer: directed events checked against an
// event-level model (delayed pins, per-event OR and a queue of pending words)
// plus literal expectations for word values and write latency.
module tb_tube_event_writer;
  import qn17_pkg::*;

  localparam int W  = 16;
  localparam int S  = 2;
  localparam int XW = EVT_WORDS - 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       SCIN_COIN;
  logic [7:0] T3A, T3B, T4A, T4B;
  logic       full;
  logic       BUSY;
  logic [7:0] DROP_CNT;

  tube_event_writer_if wr_if ();
  assign wr_if.WR_FULL = full;

  tube_event_writer #(.WINDOW(W), .SYNC_STAGES(S)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SCIN_COIN (SCIN_COIN),
    .TUBE3A    (T3A),
    .TUBE3B    (T3B),
    .TUBE4A    (T4A),
    .TUBE4B    (T4B),
    .wr        (wr_if),
    .BUSY      (BUSY),
    .DROP_CNT  (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state
  logic [32:0] hist[$];
  int          m_mode;   // 0 idle, 1 collecting, 2 words pending
  int          m_left;
  logic [31:0] m_acc;
  logic [15:0] m_words[$];
  int          m_drop;
  logic [15:0] m_evt;

  // Observations for literal checks
  logic [15:0] log_data[$];
  int          log_cyc[$];
  int          acc_cyc[$];

  task automatic model_clear();
    hist.delete();
    repeat (S + 1) hist.push_back('0);
    m_mode = 0;
    m_left = 0;
    m_acc  = '0;
    m_words.delete();
    m_drop = 0;
    m_evt  = '0;
  endtask

  task automatic build_words();
    m_words.delete();
    m_words.push_back(m_acc[31:16]);
    m_words.push_back(m_acc[15:0]);
`ifdef TUBE_EVT_TIMESTAMP_EN
    m_words.push_back(m_evt);
`endif
    m_mode = 2;
  endtask

  // Compare process: synced(t) = pin(t - S); trig = synced rise.
  initial begin
    logic [32:0] s;
    logic        trig;
    model_clear();
    forever begin
      @(negedge CLK);
      cyc++;
      if (RST) begin
        check("rst_wr_en", 32'(wr_if.WR_EN), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_drop", 32'(DROP_CNT), 0);
        check("rst_wr_data", 32'(wr_if.WR_DATA), 0);
        model_clear();
      end else begin
        s    = hist[1];
        trig = s[32] & ~hist[0][32];
        check("busy", 32'(BUSY), 32'(m_mode != 0));
        check("drop_cnt", 32'(DROP_CNT), 32'(m_drop));
        if (m_mode == 2) begin
          check("wr_en", 32'(wr_if.WR_EN), 32'(!full));
          check("wr_data", 32'(wr_if.WR_DATA), 32'(m_words[0]));
        end else begin
          check("wr_en_idle", 32'(wr_if.WR_EN), 0);
        end
        if (wr_if.WR_EN === 1'b1) begin
          log_data.push_back(wr_if.WR_DATA);
          log_cyc.push_back(cyc);
        end
        if (trig && m_mode != 0 && m_drop < 255) m_drop++;
        case (m_mode)
          0: if (trig) begin
            m_acc = s[31:0];
            acc_cyc.push_back(cyc);
            if (W == 1) build_words();
            else begin
              m_left = W - 1;
              m_mode = 1;
            end
          end
          1: begin
            m_acc = m_acc | s[31:0];
            m_left--;
            if (m_left == 0) build_words();
          end
          default: if (!full) begin
            void'(m_words.pop_front());
            if (m_words.size() == 0) begin
              m_mode = 0;
              m_evt  = m_evt + 16'd1;
            end
          end
        endcase
        hist.push_back({SCIN_COIN, T3A, T3B, T4A, T4B});
        void'(hist.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_cyc.delete();
    acc_cyc.delete();
  endtask

  // Literal check of one logged event: both data words and write latency.
  task automatic expect_event(input string name, input logic [15:0] w0, input logic [15:0] w1,
                              input int lat0, input logic [15:0] ts);
    check({name, "_nwords"}, 32'(log_data.size()), 32'(EVT_WORDS));
    check({name, "_ntrig"}, 32'(acc_cyc.size()), 1);
    if (log_data.size() >= 2 && acc_cyc.size() >= 1) begin
      check({name, "_w0"}, 32'(log_data[0]), 32'(w0));
      check({name, "_w1"}, 32'(log_data[1]), 32'(w1));
      check({name, "_lat0"}, 32'(log_cyc[0] - acc_cyc[0]), 32'(lat0));
      check({name, "_lat1"}, 32'(log_cyc[1] - acc_cyc[0]), 32'(lat0 + 1));
    end
`ifdef TUBE_EVT_TIMESTAMP_EN
    if (log_data.size() >= 3) check({name, "_ts"}, 32'(log_data[2]), 32'(ts));
`else
    if (ts != 16'hFFFF && log_data.size() > 2) check({name, "_extra"}, 32'(log_data.size()), 2);
`endif
  endtask

  // Basic-event stimulus; pin cycle p is the SCIN_COIN rise, E = p + S.
  task automatic basic_event(input int full_delay, input int full_len);
    SCIN_COIN = 1'b1;
    tick(3);
    T3A = 8'h81;
    tick(1);
    T3A = 8'h00;
    tick(11);
    T4B = 8'h10;
    tick(1);
    T4B = 8'h00;
    T3B = 8'h02;
    SCIN_COIN = 1'b0;
    if (full_len > 0) begin
      tick(full_delay);
      T3B = 8'h00;
      full = 1'b1;
      tick(full_len);
      full = 1'b0;
    end else begin
      tick(1);
      T3B = 8'h00;
    end
    tick(20);
  endtask

  initial begin
    RST = 1'b0;
    SCIN_COIN = 1'b0;
    {T3A, T3B, T4A, T4B} = '0;
    full = 1'b0;
    #1 RST = 1'b1;
    tick(3);
    RST = 1'b0;
    tick(5);

    // Reset mid-window discards the partial event
    clear_logs();
    SCIN_COIN = 1'b1;
    T3A = 8'h01;
    tick(8);
    RST = 1'b1;
    SCIN_COIN = 1'b0;
    tick(2);
    RST = 1'b0;
    tick(50);
    check("reset_no_write", 32'(log_data.size()), 0);
    check("reset_busy", 32'(BUSY), 0);
    T3A = 8'h00;
    tick(5);

    // Basic event: 3B hit at E+16 is outside the window
    clear_logs();
    basic_event(0, 0);
    expect_event("basic", 16'h8100, 16'h0010, W, 16'h0000);

    // Backpressure: full for 5 cycles from E+16
    clear_logs();
    basic_event(2, 5);
    expect_event("bp", 16'h8100, 16'h0010, W + 5, 16'h0001);

    // Empty coincidence is still written
    clear_logs();
    SCIN_COIN = 1'b1;
    tick(3);
    SCIN_COIN = 1'b0;
    tick(30);
    expect_event("empty", 16'h0000, 16'h0000, W, 16'h0002);

    // Trigger on the cycle the FSM returns to IDLE is dropped
    clear_logs();
    SCIN_COIN = 1'b1;
    tick(2);
    SCIN_COIN = 1'b0;
    tick(15 + XW);
    SCIN_COIN = 1'b1;
    tick(2);
    SCIN_COIN = 1'b0;
    tick(40);
    check("edge_drop_cnt", 32'(DROP_CNT), 1);
    check("edge_drop_words", 32'(log_data.size()), 32'(EVT_WORDS));

    // Trigger on the first IDLE cycle is accepted
    clear_logs();
    SCIN_COIN = 1'b1;
    tick(2);
    SCIN_COIN = 1'b0;
    tick(16 + XW);
    SCIN_COIN = 1'b1;
    tick(2);
    SCIN_COIN = 1'b0;
    tick(40);
    check("edge_accept_drop", 32'(DROP_CNT), 1);
    check("edge_accept_words", 32'(log_data.size()), 32'(2 * EVT_WORDS));
    check("edge_accept_trigs", 32'(acc_cyc.size()), 2);

    // Dead time: 300 triggers with the FIFO full
    clear_logs();
    full = 1'b1;
    for (int i = 0; i < 300; i++) begin
      SCIN_COIN = 1'b1;
      tick(2);
      SCIN_COIN = 1'b0;
      tick(2);
    end
    tick(4);
    check("dead_drop_sat", 32'(DROP_CNT), 32'hFF);
    check("dead_no_write", 32'(log_data.size()), 0);
    full = 1'b0;
    tick(10);
    check("dead_one_event", 32'(log_data.size()), 32'(EVT_WORDS));
    if (log_data.size() >= 2) begin
      check("dead_w0", 32'(log_data[0]), 32'h0000);
      check("dead_w1", 32'(log_data[1]), 32'h0000);
    end
    check("dead_idle", 32'(BUSY), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
